// File: rtl/tdm_demux_8ch.sv
// Receive end of an 8:1 TDM link: rebuilds 8-bit frames from a slot-ordered serial stream.
// Optional macro STRICT_SYNC_EN: require frame_sync on every slot-0 bit while receiving.
module tdm_demux_8ch #(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [2:0] slot,
  output logic       frame_err
);

  typedef enum logic {HUNT, RECEIVE} state_t;

  state_t     state, state_n;
  logic [7:0] partial, partial_n;
  logic [7:0] dout_n;
  logic [2:0] slot_n;
  logic       dv_n, err_n;
  logic [7:0] idle_cnt, idle_n;
  logic       timeout_hit;

  // The idle cycle being sampled now is the (idle_cnt+1)-th in a row.
  assign timeout_hit = (IDLE_TIMEOUT != 0) && ((int'(idle_cnt) + 1) == IDLE_TIMEOUT);

  always_comb begin
    state_n   = state;
    partial_n = partial;
    slot_n    = slot;
    dout_n    = dout;
    dv_n      = 1'b0;
    err_n     = 1'b0;
    idle_n    = idle_cnt;
    case (state)
      HUNT: begin
        idle_n = '0;
        if (din_valid && frame_sync) begin
          partial_n = {7'd0, din};
          slot_n    = 3'd1;
          state_n   = RECEIVE;
        end
      end
      RECEIVE: begin
        if (!din_valid) begin
          if (timeout_hit) begin
            state_n   = HUNT;
            slot_n    = '0;
            partial_n = '0;
            idle_n    = '0;
          end else if (idle_cnt != 8'hFF) begin
            idle_n = idle_cnt + 8'd1;
          end
        end else begin
          idle_n = '0;
          if (frame_sync) begin
            // Marker always restarts the frame; off-slot markers also flag an error.
            err_n     = (slot != 3'd0);
            partial_n = {7'd0, din};
            slot_n    = 3'd1;
          end
`ifdef STRICT_SYNC_EN
          else if (slot == 3'd0) begin
            err_n     = 1'b1;
            partial_n = '0;
            state_n   = HUNT;
          end
`endif
          else begin
            partial_n[slot] = din;
            slot_n          = slot + 3'd1;
            if (slot == 3'd7) begin
              dout_n = {din, partial[6:0]};
              dv_n   = 1'b1;
            end
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      partial    <= '0;
      slot       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_n;
      partial    <= partial_n;
      slot       <= slot_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      frame_err  <= err_n;
      idle_cnt   <= idle_n;
    end
  end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed bench for tdm_demux_8ch with a scoreboard of expected frames.
module tb_tdm_demux_8ch;
  logic       clk = 1'b0;
  logic       rst_n, din, din_valid, frame_sync;
  logic [7:0] dout;
  logic       dout_valid, frame_err;
  logic [2:0] slot;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

`ifdef STRICT_SYNC_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  tdm_demux_8ch #(.IDLE_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout), .dout_valid(dout_valid),
    .slot(slot), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every delivered frame must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_frame observed=%h expected=none", dout);
      end
      if (exp_q.size() != 0) chk("frame_data", dout, exp_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic fs, input logic d,
                      input logic exp_err, input logic exp_dv);
    @(negedge clk);
    din_valid = v; frame_sync = fs; din = d;
    @(posedge clk); #1;
    chk("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
    chk("dout_valid", {7'd0, dout_valid}, {7'd0, exp_dv});
  endtask

  task automatic send_frame(input logic [7:0] w, input logic sync,
                            input logic err0, input logic deliver);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && deliver) exp_q.push_back(w);
      step(1'b1, sync && (i == 0), w[i], (i == 0) ? err0 : 1'b0, (i == 7) && deliver);
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input logic sync);
    for (int i = 0; i < n; i++) step(1'b1, sync && (i == 0), w[i], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_dv", {7'd0, dout_valid}, 8'h00);
    chk("rst_slot", {5'd0, slot}, 8'h00);
    chk("rst_err", {7'd0, frame_err}, 8'h00);
    @(negedge clk); rst_n = 1'b1;

    // Single synced frame; pulse must drop the following cycle.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("slot_after_sync", {5'd0, slot}, 8'd1);
    exp_q.push_back(8'hA5);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, (8'hA5 >> i) & 1'b1, 1'b0, i == 7);
    chk("slot_wrap", {5'd0, slot}, 8'd0);
    idle(1);
    chk("dout_hold", dout, 8'hA5);

    // Back-to-back frames, valid continuous.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    chk("b2b_first", dout, 8'h3C);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    chk("b2b_second", dout, 8'hC3);

    // Timeout back to HUNT, unsynced bits ignored, then synced 0F.
    idle(4);
    chk("hunt_slot", {5'd0, slot}, 8'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    chk("hunt_discard_slot", {5'd0, slot}, 8'd0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1);

    // FF interrupted by a marker at slot 5, then 81.
    send_bits(8'hFF, 5, 1'b1);
    chk("slot5", {5'd0, slot}, 8'd5);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    chk("resync_dout", dout, 8'h81);

    // Idle timeout boundary: 3 idles keep RECEIVE, 4th drops to HUNT.
    send_bits(8'h07, 3, 1'b1);
    idle(3);
    chk("pre_timeout_slot", {5'd0, slot}, 8'd3);
    idle(1);
    chk("timeout_slot", {5'd0, slot}, 8'd0);
    send_bits(8'h1F, 5, 1'b0);
    chk("post_timeout_slot", {5'd0, slot}, 8'd0);
    chk("post_timeout_dout", dout, 8'h81);

    // Second frame without marker at slot 0.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    send_frame(8'h96, 1'b0, STRICT, !STRICT);
    chk("strict_dout", dout, STRICT ? 8'h5A : 8'h96);
    chk("strict_slot", {5'd0, slot}, 8'd0);

    // Mid-frame reset clears everything.
    send_bits(8'h05, 3, 1'b1);
    @(negedge clk); rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    @(posedge clk); #1;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_slot", {5'd0, slot}, 8'h00);
    chk("midrst_dv", {7'd0, dout_valid}, 8'h00);
    chk("midrst_err", {7'd0, frame_err}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    send_frame(8'hE7, 1'b1, 1'b0, 1'b1);
    chk("post_rst_dout", dout, 8'hE7);

    idle(2);
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
